// File: rtl/boot_seq_pkg.sv
// Shared state encoding and commit decision for the boot sequencer.
package boot_seq_pkg;

  typedef enum logic [2:0] {
    ST_START    = 3'd0,
    ST_WAIT_REL = 3'd1,
    ST_SEL      = 3'd2,
    ST_HELD     = 3'd3,
    ST_REARM    = 3'd4,
    ST_LOCK     = 3'd5,
    ST_BOOT     = 3'd6
  } state_t;

  // Images flagged in lock_mask need the flash locked first, unless the user opted out.
  function automatic state_t commit_target(input logic [3:0] lock_mask,
                                           input logic [1:0] sel,
                                           input logic       skip);
    if (lock_mask[sel] && !skip) return ST_LOCK;
    return ST_BOOT;
  endfunction

endpackage

// File: rtl/boot_sequencer.sv
// Boot image selection: button menu with short/long press, optional flash lock, then warmboot.
// fl_go/fl_rdy: fl_go is a one-cycle start pulse on LOCK entry; fl_rdy is a level sampled only in LOCK.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int         N_IMG       = 4,
  parameter int         DEFAULT_IMG = 2,
  parameter int         MENU_IMG    = 1,
  parameter logic [3:0] LOCK_MASK   = 4'b1111,
  parameter bit         HAS_BTN     = 1'b1,
  parameter int         TMR_W       = 24,
  parameter int         TIMEOUT_BIT = 23,
  parameter int         REARM_BIT   = 17,
  parameter int         LONG_BIT    = 22
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_v,
  input  logic       btn_r,
  input  logic       btn_f,
  output logic       fl_go,
  input  logic       fl_rdy,
  output logic [1:0] boot_sel,
  output logic       boot_now,
  output logic       boot_req,
  output logic       menu_active,
  output logic       skip_lock,
  output logic [2:0] state_dbg
);

  localparam logic [1:0] DEF_SEL  = 2'(DEFAULT_IMG);
  localparam logic [1:0] MENU_SEL = 2'(MENU_IMG);
  localparam logic [1:0] LAST_SEL = 2'(N_IMG - 1);

  state_t           state, state_nx;
  logic [TMR_W-1:0] timer, timer_nx;
  logic [1:0]       sel_nx;
  logic             skip_nx;
  logic             tick;

  always_comb begin
    tick = 1'b0;
    case (state)
      ST_SEL:   tick = timer[TIMEOUT_BIT];
      ST_REARM: tick = timer[REARM_BIT];
      ST_HELD:  tick = timer[LONG_BIT];
      default:  tick = 1'b0;
    endcase
  end

  always_comb begin
    state_nx = state;
    sel_nx   = boot_sel;
    skip_nx  = skip_lock;
    case (state)
      ST_START: begin
        if (HAS_BTN && !btn_v) begin
          state_nx = ST_WAIT_REL;
        end else begin
          sel_nx   = DEF_SEL;
          state_nx = commit_target(LOCK_MASK, DEF_SEL, skip_lock);
        end
      end
      ST_WAIT_REL: begin
        if (btn_v) begin
          sel_nx   = MENU_SEL;
          state_nx = ST_REARM;
        end
      end
      ST_SEL: begin
        if (btn_f)     state_nx = ST_HELD;
        else if (tick) state_nx = commit_target(LOCK_MASK, boot_sel, skip_lock);
      end
      ST_HELD: begin
        // A release beats the long-press tick landing in the same cycle.
        if (btn_r) begin
          sel_nx   = (boot_sel == LAST_SEL) ? 2'd0 : boot_sel + 2'd1;
          skip_nx  = skip_lock | (boot_sel == 2'd0);
          state_nx = ST_REARM;
        end else if (tick) begin
          state_nx = commit_target(LOCK_MASK, boot_sel, skip_lock);
        end
      end
      ST_REARM: begin
        if (tick) state_nx = ST_SEL;
      end
      ST_LOCK: begin
        if (fl_rdy) state_nx = ST_BOOT;
      end
      ST_BOOT:  state_nx = ST_BOOT;
      default:  state_nx = ST_START;
    endcase
  end

  // A pressed button restarts the count everywhere except HELD, where the press is being timed.
  always_comb begin
    if ((state_nx != state) || tick || (!btn_v && (state != ST_HELD))) timer_nx = '0;
    else                                                                 timer_nx = timer + TMR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_START;
      boot_sel  <= DEF_SEL;
      skip_lock <= 1'b0;
      boot_req  <= 1'b0;
      fl_go     <= 1'b0;
      timer     <= '0;
    end else begin
      state     <= state_nx;
      boot_sel  <= sel_nx;
      skip_lock <= skip_nx;
      boot_req  <= (state == ST_BOOT);
      fl_go     <= (state_nx == ST_LOCK) && (state != ST_LOCK);
      timer     <= timer_nx;
    end
  end

  assign boot_now    = (state == ST_BOOT);
  assign menu_active = (state == ST_WAIT_REL) || (state == ST_SEL) ||
                       (state == ST_HELD) || (state == ST_REARM);
  assign state_dbg   = state;

endmodule

// File: tb/tb_boot_sequencer.sv
// Self-checking bench for boot_sequencer: directed scenarios plus randomized button/flash traffic.
module tb_boot_sequencer;

  localparam int         N_IMG_P   = 3;
  localparam int         DEF_P     = 2;
  localparam int         MENU_P    = 1;
  localparam logic [3:0] MASK_P    = 4'b0110;
  localparam int         TO_BIT_P  = 7;
  localparam int         RA_BIT_P  = 3;
  localparam int         LG_BIT_P  = 5;

  // Bench-local phase names for the behavioural model.
  localparam int M_START = 0, M_WAIT = 1, M_SEL = 2, M_HELD = 3, M_REARM = 4, M_LOCK = 5, M_BOOT = 6;

  logic       clk = 1'b0;
  logic       rst, btn_v, btn_r, btn_f, fl_rdy;
  logic       fl_go, boot_now, boot_req, menu_active, skip_lock;
  logic [1:0] boot_sel;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  boot_sequencer #(
    .N_IMG(N_IMG_P), .DEFAULT_IMG(DEF_P), .MENU_IMG(MENU_P), .LOCK_MASK(MASK_P),
    .HAS_BTN(1'b1), .TMR_W(8), .TIMEOUT_BIT(TO_BIT_P), .REARM_BIT(RA_BIT_P), .LONG_BIT(LG_BIT_P)
  ) dut (
    .clk(clk), .rst(rst), .btn_v(btn_v), .btn_r(btn_r), .btn_f(btn_f),
    .fl_go(fl_go), .fl_rdy(fl_rdy), .boot_sel(boot_sel), .boot_now(boot_now),
    .boot_req(boot_req), .menu_active(menu_active), .skip_lock(skip_lock),
    .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase, m_sel, m_cnt;
  bit m_skip, m_req, m_go;

  // Cycles a phase must dwell (counted from its last restart) before its timeout fires.
  function automatic int dwell(input int ph);
    case (ph)
      M_SEL:   return 1 << TO_BIT_P;
      M_REARM: return 1 << RA_BIT_P;
      M_HELD:  return 1 << LG_BIT_P;
      default: return -1;
    endcase
  endfunction

  function automatic int commit_phase(input int sel, input bit skip);
    return (MASK_P[sel] && !skip) ? M_LOCK : M_BOOT;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int prev;
    bit fired;
    if (rst) begin
      m_phase = M_START; m_sel = DEF_P; m_skip = 0; m_req = 0; m_go = 0; m_cnt = 0;
    end else begin
      prev  = m_phase;
      fired = (m_cnt == dwell(prev));
      m_req = (prev == M_BOOT);
      case (prev)
        M_START: if (!btn_v) m_phase = M_WAIT;
                 else begin m_sel = DEF_P; m_phase = commit_phase(m_sel, m_skip); end
        M_WAIT:  if (btn_v) begin m_sel = MENU_P; m_phase = M_REARM; end
        M_SEL:   if (btn_f) m_phase = M_HELD;
                 else if (fired) m_phase = commit_phase(m_sel, m_skip);
        M_HELD:  if (btn_r) begin
                   if (m_sel == 0) m_skip = 1;
                   m_sel   = (m_sel + 1) % N_IMG_P;
                   m_phase = M_REARM;
                 end else if (fired) m_phase = commit_phase(m_sel, m_skip);
        M_REARM: if (fired) m_phase = M_SEL;
        M_LOCK:  if (fl_rdy) m_phase = M_BOOT;
        default: ;
      endcase
      m_go = (m_phase == M_LOCK) && (prev != M_LOCK);
      if (m_phase != prev || fired || (!btn_v && prev != M_HELD)) m_cnt = 0;
      else m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_boot_sel",    boot_sel,    m_sel);
      check("cyc_skip_lock",   skip_lock,   m_skip);
      check("cyc_boot_now",    boot_now,    m_phase == M_BOOT);
      check("cyc_boot_req",    boot_req,    m_req);
      check("cyc_fl_go",       fl_go,       m_go);
      check("cyc_menu_active", menu_active, m_phase inside {M_WAIT, M_SEL, M_HELD, M_REARM});
    end
  end

  // ---------------- driver tasks (all start and end just after a negedge) ----------------
  task automatic do_reset();
    #3 rst = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst_fl_go",     fl_go,     0);
    check("rst_boot_sel",  boot_sel,  DEF_P);
    check("rst_boot_req",  boot_req,  0);
    check("rst_skip_lock", skip_lock, 0);
    check("rst_boot_now",  boot_now,  0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input int h, output int go_at);
    go_at = -1;
    btn_v = 1'b0; btn_f = 1'b1;
    for (int e = 1; e <= h + 1; e++) begin
      @(negedge clk);
      if (fl_go && go_at < 0) go_at = e;
      btn_f = 1'b0; btn_r = 1'b0;
      if (e == h) begin btn_v = 1'b1; btn_r = 1'b1; end
    end
  endtask

  task automatic wait_go(input int max, output int at);
    at = -1;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (fl_go) begin at = i; break; end
    end
  endtask

  task automatic wait_boot(input int max, output int at, output bit saw_go);
    at = -1; saw_go = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (fl_go) saw_go = 1;
      if (boot_now) begin at = i; break; end
    end
  endtask

  // Reset with the button held, release it and settle into SEL showing the menu image.
  task automatic enter_menu();
    btn_v = 1'b0; fl_rdy = 1'b0;
    do_reset();
    repeat (2) @(negedge clk);
    btn_v = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int g, b;
    bit sg;
    rst = 1'b0; btn_v = 1'b1; btn_r = 1'b0; btn_f = 1'b0; fl_rdy = 1'b0;
    @(negedge clk);

    // No menu: default image 2 is lock-masked, so LOCK on the first edge.
    do_reset();
    wait_go(5, g);
    check("s1_go_latency", g, 1);
    repeat (5) @(negedge clk);
    fl_rdy = 1'b1;
    @(negedge clk);
    check("s1_boot_now", boot_now, 1);
    check("s1_boot_req_lag", boot_req, 0);
    check("s1_boot_sel", boot_sel, 2);
    @(negedge clk);
    check("s1_boot_req", boot_req, 1);
    fl_rdy = 1'b0;

    // Held at reset, released: 1 edge to REARM, 9 in REARM, 129 in SEL.
    btn_v = 1'b0;
    do_reset();
    repeat (3) @(negedge clk);
    check("s2_menu_active", menu_active, 1);
    btn_v = 1'b1;
    wait_go(300, g);
    check("s2_go_latency", g, 139);
    check("s2_boot_sel", boot_sel, 1);
    fl_rdy = 1'b1;
    @(negedge clk);
    check("s2_boot_now", boot_now, 1);
    fl_rdy = 1'b0;

    // Three short presses wrap 1->2->0->1; passing 0 sets skip_lock, so no flash lock.
    enter_menu();
    press(10, g); check("s3_p1_sel", boot_sel, 2); check("s3_p1_skip", skip_lock, 0);
    repeat (12) @(negedge clk);
    press(10, g); check("s3_p2_sel", boot_sel, 0); check("s3_p2_skip", skip_lock, 0);
    repeat (12) @(negedge clk);
    press(10, g); check("s3_p3_sel", boot_sel, 1); check("s3_p3_skip", skip_lock, 1);
    wait_boot(400, b, sg);
    check("s3_boot_reached", b > 0, 1);
    check("s3_no_fl_go", sg, 0);

    // Long press commits image 1 on the 34th edge of the press; the later release is ignored.
    enter_menu();
    press(40, g);
    check("s4_go_edge", g, 34);
    check("s4_boot_sel", boot_sel, 1);
    fl_rdy = 1'b1;
    @(negedge clk);
    check("s4_boot_now", boot_now, 1);
    check("s4_boot_sel_final", boot_sel, 1);
    fl_rdy = 1'b0;

    // Release lands exactly on the long tick: release wins.
    enter_menu();
    press(33, g);
    check("s5_no_commit", g, -1);
    check("s5_boot_sel", boot_sel, 2);
    check("s5_menu_active", menu_active, 1);

    // Reset while waiting in LOCK, then a clean rerun.
    btn_v = 1'b1; fl_rdy = 1'b0;
    do_reset();
    wait_go(5, g);
    check("s6_go_first", g, 1);
    repeat (3) @(negedge clk);
    do_reset();
    wait_go(5, g);
    check("s6_go_again", g, 1);
    fl_rdy = 1'b1;
    @(negedge clk);
    check("s6_boot_now", boot_now, 1);
    check("s6_boot_sel", boot_sel, 2);
    fl_rdy = 1'b0;

    // Randomized traffic against the model.
    for (int run = 0; run < 8; run++) begin
      btn_v = 1'($urandom_range(0, 1)); fl_rdy = 1'b0;
      do_reset();
      for (int op = 0; op < 30; op++) begin
        int sel_op;
        sel_op = $urandom_range(0, 9);
        if (sel_op <= 3) begin
          btn_v = 1'b1;
          repeat ($urandom_range(1, 40)) begin
            fl_rdy = ($urandom_range(0, 3) == 0);
            @(negedge clk);
          end
        end else if (sel_op <= 7) begin
          press($urandom_range(1, 45), g);
        end else if (sel_op == 8) begin
          fl_rdy = 1'b1;
          @(negedge clk);
          fl_rdy = 1'b0;
        end else begin
          btn_v = 1'($urandom_range(0, 1));
          do_reset();
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
